aes_comm_ctrl: RTL and testbench

AES_COMM_CTRL -- requirements
Module: aes_comm_ctrl

---
 rtl/aes_comm_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes_comm_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_comm_ctrl.sv
// Sequences UART key/plaintext blocks into an AES core and streams ciphertext bytes back out.
// aes_start fires 2 cycles after the plaintext strobe; blocks arriving while busy are dropped and flagged.
module aes_comm_ctrl #(
   parameter int AES_TIMEOUT = 1024,
   parameter int TX_GAP      = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [127:0] blk_in,
   input  logic         blk_valid,
   input  logic         rekey,
   output logic [127:0] aes_key,
   output logic [127:0] aes_pt,
   output logic         aes_start,
   input  logic         aes_done,
   input  logic [127:0] aes_ct,
   output logic [7:0]   tx_data,
   output logic         tx_start,
   input  logic         tx_done,
   output logic         trig,
   output logic         busy,
   output logic         overrun,
   output logic         timeout_err
);
   localparam int TW = (AES_TIMEOUT > 1) ? $clog2(AES_TIMEOUT) : 1;
   localparam int GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(AES_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(TX_GAP);

   typedef enum logic [2:0] {WAIT_KEY, WAIT_PT, START, RUN, SEND, GAP} state_t;

   state_t          state_q, state_d;
   logic [127:0]    key_q, key_d, pt_q, pt_d, shift_q, shift_d;
   logic [3:0]      byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            sent_q, sent_d;
   logic            rekey_pend_q, rekey_pend_d;
   logic            overrun_q, overrun_d;
   logic            tmo_err_q, tmo_err_d;
   logic            aes_start_q, aes_start_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WAIT_KEY;
         key_q        <= '0;
         pt_q         <= '0;
         shift_q      <= '0;
         byte_cnt_q   <= '0;
         tmo_q        <= '0;
         gap_q        <= '0;
         sent_q       <= 1'b0;
         rekey_pend_q <= 1'b0;
         overrun_q    <= 1'b0;
         tmo_err_q    <= 1'b0;
         aes_start_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         pt_q         <= pt_d;
         shift_q      <= shift_d;
         byte_cnt_q   <= byte_cnt_d;
         tmo_q        <= tmo_d;
         gap_q        <= gap_d;
         sent_q       <= sent_d;
         rekey_pend_q <= rekey_pend_d;
         overrun_q    <= overrun_d;
         tmo_err_q    <= tmo_err_d;
         aes_start_q  <= aes_start_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      pt_d         = pt_q;
      shift_d      = shift_q;
      byte_cnt_d   = byte_cnt_q;
      tmo_d        = tmo_q;
      gap_d        = gap_q;
      sent_d       = sent_q;
      tmo_err_d    = tmo_err_q;
      aes_start_d  = 1'b0;
      rekey_pend_d = rekey_pend_q | (rekey & busy);
      overrun_d    = overrun_q | (blk_valid & busy);
      case (state_q)
         WAIT_KEY: if (blk_valid) begin
            key_d   = blk_in;
            state_d = WAIT_PT;
         end
         WAIT_PT: if (rekey) begin
            state_d = WAIT_KEY;
         end else if (blk_valid) begin
            pt_d    = blk_in;
            state_d = START;
         end
         START: begin
            aes_start_d = 1'b1;
            tmo_d       = '0;
            state_d     = RUN;
         end
         RUN: if (aes_done) begin
            shift_d    = aes_ct;
            byte_cnt_d = '0;
            sent_d     = 1'b0;
            state_d    = SEND;
         end else if (tmo_q == TMO_LAST) begin
            tmo_err_d = 1'b1;
            state_d   = WAIT_PT;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
         SEND: if (!sent_q) begin
            sent_d = 1'b1;
         end else if (tx_done) begin
            shift_d    = {shift_q[119:0], 8'h00};
            byte_cnt_d = byte_cnt_q + 4'd1;
            sent_d     = 1'b0;
            gap_d      = '0;
            state_d    = (byte_cnt_q == 4'hF) ? WAIT_PT : GAP;
         end
         GAP: if (gap_q == GAP_LAST) state_d = SEND;
              else gap_d = gap_q + GW'(1);
         default: state_d = WAIT_KEY;
      endcase
      // A rekey held during a busy phase redirects the return to idle into key loading.
      if (state_d == WAIT_PT && rekey_pend_d) begin
         state_d      = WAIT_KEY;
         rekey_pend_d = 1'b0;
      end
   end

   always_comb begin
      busy     = !(state_q == WAIT_KEY || state_q == WAIT_PT);
      trig     = (state_q == RUN);
      tx_start = (state_q == SEND) && !sent_q;
   end

   assign aes_key     = key_q;
   assign aes_pt      = pt_q;
   assign aes_start   = aes_start_q;
   assign tx_data     = shift_q[127:120];
   assign overrun     = overrun_q;
   assign timeout_err = tmo_err_q;
endmodule

// File: tb/tb_aes_comm_ctrl.sv
// Scoreboarded bench for aes_comm_ctrl: behavioural AES core and UART transmitter responders.
module tb_aes_comm_ctrl;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [127:0] blk_in = '0;
   logic         blk_valid = 1'b0;
   logic         rekey = 1'b0;
   logic [127:0] aes_key, aes_pt;
   logic         aes_start;
   logic         aes_done = 1'b0;
   logic [127:0] aes_ct = '0;
   logic [7:0]   tx_data;
   logic         tx_start;
   logic         tx_done = 1'b0;
   logic         trig, busy, overrun, timeout_err;

   always #5 clk = ~clk;

   aes_comm_ctrl #(.AES_TIMEOUT(8), .TX_GAP(0)) dut (
      .clk(clk), .reset(reset), .blk_in(blk_in), .blk_valid(blk_valid), .rekey(rekey),
      .aes_key(aes_key), .aes_pt(aes_pt), .aes_start(aes_start), .aes_done(aes_done),
      .aes_ct(aes_ct), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
      .trig(trig), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
   );

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K3  = 128'hfedcba9876543210f0e1d2c3b4a59687;

   int           n_chk = 0, n_fail = 0;
   logic [7:0]   exp_q[$];
   logic [7:0]   exp_b;
   int           tx_starts = 0, aes_starts = 0;
   bit           tx_pend_mon = 1'b0;
   bit           aes_auto = 1'b1;
   logic [127:0] ct_next = CT1;
   int           aes_cnt = 0, tx_cnt = 0;

   // AES core model: answers 3 cycles after aes_start and queues the expected byte stream.
   always begin
      @(posedge clk); #1;
      aes_done = 1'b0;
      if (reset) aes_cnt = 0;
      else if (aes_cnt != 0) begin
         aes_cnt--;
         if (aes_cnt == 0) begin
            aes_done = 1'b1;
            aes_ct   = ct_next;
            for (int i = 15; i >= 0; i--) exp_q.push_back(ct_next[i*8 +: 8]);
         end
      end else if (aes_start && aes_auto) aes_cnt = 3;
   end

   // UART transmitter model: tx_done 5 cycles after each tx_start.
   always begin
      @(posedge clk); #1;
      tx_done = 1'b0;
      if (reset) tx_cnt = 0;
      else if (tx_cnt != 0) begin
         tx_cnt--;
         if (tx_cnt == 0) tx_done = 1'b1;
      end else if (tx_start) tx_cnt = 5;
   end

   always @(negedge clk) begin
      if (aes_start) aes_starts++;
      if (tx_done) tx_pend_mon = 1'b0;
      if (tx_start) begin
         tx_starts++;
         n_chk++;
         if (tx_pend_mon) begin
            n_fail++;
            $display("FAIL tx_start_early: tx_start=1 while previous byte unfinished, required 0");
         end
         tx_pend_mon = 1'b1;
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL tx_unexpected: tx_data=%h sent, required no tx_start", tx_data);
         end else begin
            exp_b = exp_q.pop_front();
            if (tx_data !== exp_b) begin
               n_fail++;
               $display("FAIL tx_byte: tx_data=%h required %h", tx_data, exp_b);
            end
         end
      end
   end

   task automatic send_blk(input logic [127:0] d);
      @(posedge clk); #1;
      blk_in = d; blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_tx(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (tx_starts >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++; if (aes_key !== '0)     begin n_fail++; $display("FAIL rst_key: %h required 0", aes_key); end
      n_chk++; if (aes_pt !== '0)      begin n_fail++; $display("FAIL rst_pt: %h required 0", aes_pt); end
      n_chk++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL rst_tx_data: %h required 00", tx_data); end
      n_chk++; if ({aes_start, tx_start, trig, busy, overrun, timeout_err} !== 6'b0)
         begin n_fail++; $display("FAIL rst_flags: %b required 000000", {aes_start, tx_start, trig, busy, overrun, timeout_err}); end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_encrypt;
      bit ok;
      int base = tx_starts;
      ct_next = CT1;
      send_blk(K1);
      @(negedge clk);
      n_chk++; if (aes_key !== K1) begin n_fail++; $display("FAIL key_latch: %h required %h", aes_key, K1); end
      n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL busy_wait_pt: %b required 0", busy); end
      send_blk(PT1);
      @(negedge clk);
      n_chk++; if (aes_start !== 1'b0) begin n_fail++; $display("FAIL start_early: %b required 0", aes_start); end
      n_chk++; if (busy !== 1'b1)      begin n_fail++; $display("FAIL busy_start: %b required 1", busy); end
      @(negedge clk);
      n_chk++; if (aes_start !== 1'b1) begin n_fail++; $display("FAIL start_latency: %b required 1", aes_start); end
      n_chk++; if (trig !== 1'b1)      begin n_fail++; $display("FAIL trig_run: %b required 1", trig); end
      n_chk++; if (aes_pt !== PT1)     begin n_fail++; $display("FAIL pt_latch: %h required %h", aes_pt, PT1); end
      @(negedge clk);
      n_chk++; if (aes_start !== 1'b0) begin n_fail++; $display("FAIL start_width: %b required 0", aes_start); end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL enc_idle: busy stuck 1, required 0"); end
      n_chk++; if (tx_starts - base != 16) begin n_fail++; $display("FAIL enc_count: %0d bytes required 16", tx_starts - base); end
      n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL enc_left: %0d bytes unsent required 0", exp_q.size()); end
      n_chk++; if (trig !== 1'b0) begin n_fail++; $display("FAIL enc_trig: %b required 0", trig); end
   endtask

   task automatic test_rekey_collision;
      int st = aes_starts;
      @(posedge clk); #1;
      blk_in = 128'h5555; blk_valid = 1'b1; rekey = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0; rekey = 1'b0;
      @(negedge clk);
      n_chk++; if (aes_pt !== PT1)    begin n_fail++; $display("FAIL coll_pt: %h required %h", aes_pt, PT1); end
      n_chk++; if (overrun !== 1'b0)  begin n_fail++; $display("FAIL coll_overrun: %b required 0", overrun); end
      send_blk(K2);
      @(negedge clk);
      n_chk++; if (aes_key !== K2)    begin n_fail++; $display("FAIL coll_newkey: %h required %h", aes_key, K2); end
      n_chk++; if (busy !== 1'b0 || aes_starts != st)
         begin n_fail++; $display("FAIL coll_nostart: busy=%b starts=%0d required 0/%0d", busy, aes_starts, st); end
   endtask

   task automatic test_overrun;
      bit ok;
      int base = tx_starts;
      logic [127:0] pt2 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      ct_next = 128'h3925841d02dc09fbdc118597196a0b32;
      send_blk(pt2);
      wait_tx(base + 3, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL ovr_wait: tx_start never reached 3, required 3"); end
      send_blk(128'hdeadbeefdeadbeefdeadbeefdeadbeef);
      @(negedge clk);
      n_chk++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: %b required 1", overrun); end
      n_chk++; if (aes_pt !== pt2)   begin n_fail++; $display("FAIL ovr_pt: %h required %h", aes_pt, pt2); end
      wait_idle(ok);
      n_chk++; if (!ok || tx_starts - base != 16) begin n_fail++; $display("FAIL ovr_count: %0d bytes required 16", tx_starts - base); end
      n_chk++; if (aes_key !== K2) begin n_fail++; $display("FAIL key_persist: %h required %h", aes_key, K2); end
   endtask

   task automatic test_timeout;
      bit ok;
      int run_cyc = 0;
      int base = tx_starts;
      aes_auto = 1'b0;
      send_blk(PT1);
      for (int i = 0; i < 10 && !trig; i++) @(negedge clk);
      for (int i = 0; i < 50 && trig; i++) begin run_cyc++; @(negedge clk); end
      n_chk++; if (run_cyc != 8)        begin n_fail++; $display("FAIL tmo_cycles: %0d RUN cycles required 8", run_cyc); end
      n_chk++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: %b required 1", timeout_err); end
      n_chk++; if (trig !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_state: trig=%b busy=%b required 0/0", trig, busy); end
      n_chk++; if (tx_starts != base)   begin n_fail++; $display("FAIL tmo_tx: %0d bytes required 0", tx_starts - base); end
      aes_auto = 1'b1;
      ct_next = 128'h8ea2b7ca516745bfeafc49904b496089;
      send_blk(PT1);
      wait_idle(ok);
      n_chk++; if (!ok || tx_starts - base != 16) begin n_fail++; $display("FAIL tmo_recover: %0d bytes required 16", tx_starts - base); end
   endtask

   task automatic test_rekey_send;
      bit ok;
      int base = tx_starts;
      int st;
      ct_next = 128'hdd3e7c0b4aef6e93c1d0c2b97a6c4512;
      send_blk(PT1);
      wait_tx(base + 2, ok);
      @(posedge clk); #1; rekey = 1'b1;
      @(posedge clk); #1; rekey = 1'b0;
      wait_idle(ok);
      n_chk++; if (!ok || tx_starts - base != 16) begin n_fail++; $display("FAIL rk_count: %0d bytes required 16", tx_starts - base); end
      n_chk++; if (aes_key !== K2) begin n_fail++; $display("FAIL rk_oldkey: %h required %h", aes_key, K2); end
      st = aes_starts;
      send_blk(K3);
      @(negedge clk);
      n_chk++; if (aes_key !== K3 || busy !== 1'b0 || aes_starts != st)
         begin n_fail++; $display("FAIL rk_newkey: key=%h busy=%b required %h/0", aes_key, busy, K3); end
      send_blk(PT1);
      @(negedge clk); @(negedge clk);
      n_chk++; if (aes_start !== 1'b1 || aes_key !== K3)
         begin n_fail++; $display("FAIL rk_start: start=%b key=%h required 1/%h", aes_start, aes_key, K3); end
      wait_idle(ok);
      n_chk++; if (!ok || tx_starts - base != 32) begin n_fail++; $display("FAIL rk_second: %0d bytes required 32", tx_starts - base); end
   endtask

   task automatic test_reset_mid_send;
      bit ok;
      int base = tx_starts;
      int st;
      ct_next = CT1;
      send_blk(PT1);
      wait_tx(base + 7, ok);
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      exp_q.delete();
      tx_pend_mon = 1'b0;
      @(negedge clk);
      n_chk++; if (aes_key !== '0 || aes_pt !== '0 || tx_data !== 8'h00)
         begin n_fail++; $display("FAIL mid_rst_data: key=%h pt=%h tx=%h required 0", aes_key, aes_pt, tx_data); end
      n_chk++; if ({aes_start, tx_start, trig, busy, overrun, timeout_err} !== 6'b0)
         begin n_fail++; $display("FAIL mid_rst_flags: %b required 000000", {aes_start, tx_start, trig, busy, overrun, timeout_err}); end
      st = aes_starts;
      repeat (40) @(negedge clk);
      n_chk++; if (tx_starts != base + 7) begin n_fail++; $display("FAIL mid_rst_tx: %0d bytes required 7", tx_starts - base); end
      send_blk(PT1);
      @(negedge clk); @(negedge clk);
      n_chk++; if (aes_key !== PT1 || aes_starts != st || busy !== 1'b0)
         begin n_fail++; $display("FAIL mid_rst_key: key=%h starts=%0d required %h/%0d", aes_key, aes_starts, PT1, st); end
      send_blk(PT1);
      wait_idle(ok);
      n_chk++; if (!ok || tx_starts != base + 23) begin n_fail++; $display("FAIL mid_rst_resume: %0d bytes required 23", tx_starts - base); end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_rekey_collision();
      test_overrun();
      test_timeout();
      test_rekey_send();
      test_reset_mid_send();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
